// File: rtl/led_frame.sv
// APA102-style frame sequencer: start frame, 4-byte LED records from pixel RAM, end frame,
// one byte per SPI start/busy handshake. Optional auto-repeat via FRAME_AUTO_REPEAT_EN.
module led_frame #(
  parameter int unsigned NUM_LEDS   = 60,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned END_BYTES  = 4
`ifdef FRAME_AUTO_REPEAT_EN
  ,
  parameter int unsigned REFRESH_GAP = 1000
`endif
) (
  input  logic                  frame_clk,
  input  logic                  frame_reset,
  input  logic                  frame_start,
  input  logic [4:0]            frame_brightness,
  output logic                  frame_busy,
  output logic                  frame_done,
  output logic [ADDR_WIDTH-1:0] pix_addr,
  input  logic [23:0]           pix_data,
  output logic                  spi_start,
  output logic [7:0]            spi_data,
  input  logic                  spi_busy
);

  localparam int unsigned MaxBytes = (END_BYTES > 4) ? END_BYTES : 4;
  localparam int unsigned CntW     = $clog2(MaxBytes);
  localparam logic [ADDR_WIDTH-1:0] LastLed = ADDR_WIDTH'(NUM_LEDS - 1);
  localparam logic [CntW-1:0]       LastEnd = CntW'(END_BYTES - 1);
  localparam logic [CntW-1:0]       LastSof = CntW'(3);
`ifdef FRAME_AUTO_REPEAT_EN
  localparam int unsigned GapW = (REFRESH_GAP > 1) ? $clog2(REFRESH_GAP) : 1;
  localparam logic [GapW-1:0] LastGap = GapW'(REFRESH_GAP - 1);
`endif

  typedef enum logic [3:0] {
    StIdle, StStartFrame, StFetch, StFetchWait, StLedByte,
    StEndFrame, StSend, StWaitAck, StWaitDone, StGap
  } state_e;

  // Which section issued the byte in flight; selects the step after WAIT_DONE.
  typedef enum logic [1:0] {PhStart, PhLed, PhEnd} phase_e;

  state_e                state_q, state_d;
  phase_e                phase_q, phase_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] led_q, led_d;
  logic [1:0]            sub_q, sub_d;
  logic [4:0]            bright_q, bright_d;
  logic [23:0]           colour_q, colour_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  start_q, start_d;
  logic [7:0]            data_q, data_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
`ifdef FRAME_AUTO_REPEAT_EN
  logic [GapW-1:0]       gap_q, gap_d;
`endif
  logic                  launch, recapture;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    led_d     = led_q;
    sub_d     = sub_q;
    bright_d  = bright_q;
    colour_d  = colour_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    start_d   = start_q;
    data_d    = data_q;
    addr_d    = addr_q;
`ifdef FRAME_AUTO_REPEAT_EN
    gap_d     = gap_q;
`endif
    launch    = 1'b0;
    recapture = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          launch    = 1'b1;
          recapture = 1'b1;
        end
      end
      StStartFrame: begin
        data_d  = 8'h00;
        phase_d = PhStart;
        state_d = StSend;
      end
      StFetch:     state_d = StFetchWait;
      // pix_addr has been on the pins since entering FETCH, so RAM data is valid now.
      StFetchWait: begin
        colour_d = pix_data;
        sub_d    = 2'd0;
        state_d  = StLedByte;
      end
      StLedByte: begin
        unique case (sub_q)
          2'd0: data_d = {3'b111, bright_q};
          2'd1: data_d = colour_q[7:0];
          2'd2: data_d = colour_q[15:8];
          2'd3: data_d = colour_q[23:16];
        endcase
        phase_d = PhLed;
        state_d = StSend;
      end
      StEndFrame: begin
        data_d  = 8'hFF;
        phase_d = PhEnd;
        state_d = StSend;
      end
      StSend: begin
        start_d = 1'b1;
        state_d = StWaitAck;
      end
      StWaitAck: begin
        if (spi_busy) begin
          start_d = 1'b0;
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (!spi_busy) begin
          unique case (phase_q)
            PhStart: begin
              if (cnt_q == LastSof) begin
                cnt_d   = '0;
                led_d   = '0;
                addr_d  = '0;
                state_d = StFetch;
              end else begin
                cnt_d   = cnt_q + 1'b1;
                state_d = StStartFrame;
              end
            end
            PhLed: begin
              if (sub_q != 2'd3) begin
                sub_d   = sub_q + 1'b1;
                state_d = StLedByte;
              end else if (led_q == LastLed) begin
                cnt_d   = '0;
                state_d = StEndFrame;
              end else begin
                led_d   = led_q + 1'b1;
                addr_d  = led_q + 1'b1;
                state_d = StFetch;
              end
            end
            PhEnd: begin
              if (cnt_q == LastEnd) begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
`ifdef FRAME_AUTO_REPEAT_EN
                gap_d   = '0;
                state_d = StGap;
`else
                state_d = StIdle;
`endif
              end else begin
                cnt_d   = cnt_q + 1'b1;
                state_d = StEndFrame;
              end
            end
            default: state_d = StIdle;
          endcase
        end
      end
`ifdef FRAME_AUTO_REPEAT_EN
      StGap: begin
        if (frame_start) begin
          launch    = 1'b1;
          recapture = 1'b1;
        end else if (gap_q == LastGap) begin
          launch = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    if (launch) begin
      busy_d  = 1'b1;
      cnt_d   = '0;
      led_d   = '0;
      sub_d   = 2'd0;
      state_d = StStartFrame;
      if (recapture) bright_d = frame_brightness;
    end
  end

  always_ff @(posedge frame_clk) begin
    if (frame_reset) begin
      state_q  <= StIdle;
      phase_q  <= PhStart;
      cnt_q    <= '0;
      led_q    <= '0;
      sub_q    <= 2'd0;
      bright_q <= 5'd0;
      colour_q <= 24'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
      data_q   <= 8'd0;
      addr_q   <= '0;
`ifdef FRAME_AUTO_REPEAT_EN
      gap_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      led_q    <= led_d;
      sub_q    <= sub_d;
      bright_q <= bright_d;
      colour_q <= colour_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      start_q  <= start_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
`ifdef FRAME_AUTO_REPEAT_EN
      gap_q    <= gap_d;
`endif
    end
  end

  assign frame_busy = busy_q;
  assign frame_done = done_q;
  assign pix_addr   = addr_q;
  assign spi_start  = start_q;
  assign spi_data   = data_q;

endmodule

// File: tb/tb_led_frame.sv
// Directed bench for led_frame: 2 LEDs, 1 end byte, slow SPI writer model, sync pixel RAM model.
module tb_led_frame;

  logic       frame_clk;
  logic       frame_reset;
  logic       frame_start;
  logic [4:0] frame_brightness;
  logic       frame_busy;
  logic       frame_done;
  logic [1:0] pix_addr;
  logic [23:0] pix_data;
  logic       spi_start;
  logic [7:0] spi_data;
  logic       spi_busy;

  int errors = 0;
  int checks = 0;

  led_frame #(
    .NUM_LEDS(2),
    .ADDR_WIDTH(2),
    .END_BYTES(1)
`ifdef FRAME_AUTO_REPEAT_EN
    ,
    .REFRESH_GAP(10)
`endif
  ) dut (
    .frame_clk(frame_clk),
    .frame_reset(frame_reset),
    .frame_start(frame_start),
    .frame_brightness(frame_brightness),
    .frame_busy(frame_busy),
    .frame_done(frame_done),
    .pix_addr(pix_addr),
    .pix_data(pix_data),
    .spi_start(spi_start),
    .spi_data(spi_data),
    .spi_busy(spi_busy)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  // Sync pixel RAM; in strict mode the data is valid only in the cycle right after an address change.
  logic [23:0] ram [4];
  logic        strict = 1'b0;
  logic [1:0]  pa_prev = 2'd0;
  initial begin
    ram[0] = 24'h112233;
    ram[1] = 24'hAABBCC;
    ram[2] = 24'h0;
    ram[3] = 24'h0;
    pix_data = 24'h0;
  end
  always @(posedge frame_clk) begin
    pa_prev <= pix_addr;
    if (!strict || pix_addr != pa_prev) pix_data <= ram[pix_addr];
    else pix_data <= 24'h5A5A5A;
  end

  // SPI writer model: busy rises 3 cycles after start is seen, stays 20 cycles.
  logic [7:0] bytes [$];
  int         m_phase = 0;
  int         m_cnt = 0;
  logic [7:0] m_data = 8'h0;
  int         viol_data = 0;
  int         viol_early = 0;
  int         viol_late = 0;
  initial spi_busy = 1'b0;
  always @(posedge frame_clk) begin
    if (frame_reset) begin
      spi_busy <= 1'b0;
      m_phase  <= 0;
      m_cnt    <= 0;
    end else begin
      case (m_phase)
        0: if (spi_start) begin
          bytes.push_back(spi_data);
          m_data  <= spi_data;
          m_phase <= 1;
          m_cnt   <= 3;
        end
        1: begin
          if (spi_data !== m_data) viol_data++;
          if (spi_start !== 1'b1) viol_early++;
          if (m_cnt == 1) begin
            spi_busy <= 1'b1;
            m_phase  <= 2;
            m_cnt    <= 20;
          end else m_cnt <= m_cnt - 1;
        end
        default: begin
          if (spi_data !== m_data) viol_data++;
          if (m_cnt < 20 && spi_start !== 1'b0) viol_late++;
          if (m_cnt == 1) begin
            spi_busy <= 1'b0;
            m_phase  <= 0;
          end else m_cnt <= m_cnt - 1;
        end
      endcase
    end
  end

  function automatic logic [7:0] exp_byte(input int i, input logic [4:0] b);
    logic [23:0] c;
    int sub;
    if (i < 4) return 8'h00;
    if (i >= 12) return 8'hFF;
    c   = ((i - 4) / 4 == 0) ? 24'h112233 : 24'hAABBCC;
    sub = (i - 4) % 4;
    case (sub)
      0: return {3'b111, b};
      1: return c[7:0];
      2: return c[15:8];
      default: return c[23:16];
    endcase
  endfunction

  task automatic tick();
    @(negedge frame_clk);
  endtask

  task automatic pulse_start(input logic [4:0] b);
    frame_brightness = b;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen, output logic busy_prev,
                           output logic busy_at);
    logic prev;
    seen = 1'b0;
    busy_prev = 1'bx;
    busy_at = 1'bx;
    prev = frame_busy;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (frame_done === 1'b1) begin
        seen = 1'b1;
        busy_prev = prev;
        busy_at = frame_busy;
        break;
      end
      prev = frame_busy;
    end
  endtask

  task automatic test_reset();
    frame_reset = 1'b1;
    frame_start = 1'b0;
    frame_brightness = 5'h0;
    repeat (3) tick();
    checks++; if (frame_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", frame_busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", frame_done); end
    checks++; if (spi_start !== 1'b0) begin errors++; $display("FAIL reset_spi_start: got %b want 0", spi_start); end
    checks++; if (spi_data !== 8'h00) begin errors++; $display("FAIL reset_spi_data: got %h want 00", spi_data); end
    checks++; if (pix_addr !== 2'd0) begin errors++; $display("FAIL reset_pix_addr: got %0d want 0", pix_addr); end
    frame_reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_frame(input string tag);
    bit seen;
    logic bp, ba;
    bytes.delete();
    viol_data = 0; viol_early = 0; viol_late = 0;
    pulse_start(5'h1F);
    checks++; if (frame_busy !== 1'b1) begin errors++; $display("FAIL %s_busy_rise: got %b want 1", tag, frame_busy); end
    wait_done(2000, seen, bp, ba);
    checks++; if (!seen) begin errors++; $display("FAIL %s_done_timeout: got no frame_done want pulse", tag); end
    checks++; if (bp !== 1'b1) begin errors++; $display("FAIL %s_busy_before_done: got %b want 1", tag, bp); end
    checks++; if (ba !== 1'b0) begin errors++; $display("FAIL %s_busy_at_done: got %b want 0", tag, ba); end
    tick();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL %s_done_width: got %b want 0", tag, frame_done); end
    checks++; if (bytes.size() != 13) begin errors++; $display("FAIL %s_byte_count: got %0d want 13", tag, bytes.size()); end
    for (int i = 0; i < 13; i++) begin
      logic [7:0] got;
      got = (i < bytes.size()) ? bytes[i] : 8'hxx;
      checks++;
      if (got !== exp_byte(i, 5'h1F)) begin
        errors++; $display("FAIL %s_byte%0d: got %h want %h", tag, i, got, exp_byte(i, 5'h1F));
      end
    end
    checks++; if (viol_data != 0) begin errors++; $display("FAIL %s_data_stable: got %0d changes want 0", tag, viol_data); end
    checks++; if (viol_early != 0) begin errors++; $display("FAIL %s_start_held: got %0d drops want 0", tag, viol_early); end
    checks++; if (viol_late != 0) begin errors++; $display("FAIL %s_start_released: got %0d highs want 0", tag, viol_late); end
  endtask

  task automatic test_ignore_start();
    bit seen;
    logic bp, ba;
    int busy_seen;
    int n;
    bytes.delete();
    pulse_start(5'h1F);
    n = 0;
    while (bytes.size() < 6 && n < 1000) begin tick(); n++; end
    pulse_start(5'h00);
    wait_done(2000, seen, bp, ba);
    checks++; if (!seen) begin errors++; $display("FAIL ignore_done_timeout: got no frame_done want pulse"); end
    checks++; if (bytes.size() != 13) begin errors++; $display("FAIL ignore_byte_count: got %0d want 13", bytes.size()); end
    for (int i = 4; i < 12; i += 4) begin
      logic [7:0] got;
      got = (i < bytes.size()) ? bytes[i] : 8'hxx;
      checks++;
      if (got !== 8'hFF) begin errors++; $display("FAIL ignore_bright%0d: got %h want ff", i, got); end
    end
    busy_seen = 0;
    for (int i = 0; i < 60; i++) begin tick(); if (frame_busy !== 1'b0) busy_seen++; end
    checks++; if (busy_seen != 0) begin errors++; $display("FAIL no_second_frame: got %0d busy cycles want 0", busy_seen); end
    checks++; if (bytes.size() != 13) begin errors++; $display("FAIL no_extra_bytes: got %0d want 13", bytes.size()); end
    bytes.delete();
    pulse_start(5'h00);
    wait_done(2000, seen, bp, ba);
    checks++; if (bytes.size() != 13) begin errors++; $display("FAIL dim_byte_count: got %0d want 13", bytes.size()); end
    for (int i = 0; i < 13; i++) begin
      logic [7:0] got;
      got = (i < bytes.size()) ? bytes[i] : 8'hxx;
      checks++;
      if (got !== exp_byte(i, 5'h00)) begin
        errors++; $display("FAIL dim_byte%0d: got %h want %h", i, got, exp_byte(i, 5'h00));
      end
    end
  endtask

  task automatic test_mid_reset();
    int n;
    int busy_seen;
    bytes.delete();
    pulse_start(5'h1F);
    n = 0;
    while (bytes.size() < 11 && n < 2000) begin tick(); n++; end
    checks++; if (bytes.size() != 11) begin errors++; $display("FAIL midreset_reach_g: got %0d bytes want 11", bytes.size()); end
    frame_reset = 1'b1;
    tick();
    checks++; if (spi_start !== 1'b0) begin errors++; $display("FAIL midreset_spi_start: got %b want 0", spi_start); end
    checks++; if (frame_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", frame_busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b want 0", frame_done); end
    frame_reset = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (frame_busy !== 1'b0 || spi_start !== 1'b0) busy_seen++; end
    checks++; if (busy_seen != 0) begin errors++; $display("FAIL midreset_idle: got %0d active cycles want 0", busy_seen); end
    checks++; if (bytes.size() != 11) begin errors++; $display("FAIL midreset_no_eof: got %0d bytes want 11", bytes.size()); end
  endtask

`ifdef FRAME_AUTO_REPEAT_EN
  task automatic test_auto_repeat();
    bit seen;
    logic bp, ba;
    int gap;
    bytes.delete();
    pulse_start(5'h1F);
    wait_done(2000, seen, bp, ba);
    checks++; if (!seen) begin errors++; $display("FAIL auto_first_done: got no frame_done want pulse"); end
    gap = 0;
    while (frame_busy !== 1'b1 && gap < 100) begin tick(); gap++; end
    checks++; if (gap != 10) begin errors++; $display("FAIL auto_gap: got %0d cycles want 10", gap); end
    wait_done(2000, seen, bp, ba);
    checks++; if (bytes.size() != 26) begin errors++; $display("FAIL auto_bytes: got %0d want 26", bytes.size()); end
    checks++; if (bytes.size() > 17 && bytes[17] !== 8'hFF) begin errors++; $display("FAIL auto_bright: got %h want ff", bytes[17]); end
    frame_reset = 1'b1;
    tick();
    frame_reset = 1'b0;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_reset = 1'b1;
    frame_start = 1'b0;
    frame_brightness = 5'h0;
    tick();
    test_reset();
`ifdef FRAME_AUTO_REPEAT_EN
    test_auto_repeat();
`else
    strict = 1'b0;
    test_basic_frame("basic");
    strict = 1'b1;
    test_basic_frame("capture");
    test_ignore_start();
    test_mid_reset();
    strict = 1'b0;
    test_basic_frame("after_reset");
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
